// File: rtl/split_pkg.sv
// Shared types and defaults for the split-constraint assignment enumerator.
package split_pkg;

  localparam int SPLIT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    PROBE,
    DRAIN,
    DONE
  } enum_state_t;

endpackage

// File: rtl/split_assign_enum_if.sv
// Checker + solution stream bundle: the generator is the master, checker/consumer the slave.
interface split_assign_enum_if
  import split_pkg::*;
#(
  parameter int W = SPLIT_W
);

  logic [W-1:0] cand;
  logic         chk_x;
  logic         sol_valid;
  logic         sol_ready;
  logic [W-1:0] sol_data;

  modport master (
    output cand,
    output sol_valid,
    output sol_data,
    input  chk_x,
    input  sol_ready
  );

  modport slave (
    input  cand,
    input  sol_valid,
    input  sol_data,
    output chk_x,
    output sol_ready
  );

endinterface

// File: rtl/split_sol_slot.sv
// Single-entry valid/ready output register; flush beats load beats accept.
module split_sol_slot
  import split_pkg::*;
#(
  parameter int W = SPLIT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         accept_i,
  input  logic         flush_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (accept_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/split_assign_enum.sv
// Enumerates a range of packed candidates against a split checker and streams the hits.
module split_assign_enum
  import split_pkg::*;
#(
  parameter int W       = SPLIT_W,
  parameter int MAX_SOL = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [W-1:0]        cfg_base,
  input  logic [W:0]          cfg_limit,
  split_assign_enum_if.master bus,
  output logic                busy,
  output logic                done,
  output logic [W:0]          sol_count,
  output logic                exhausted
);

  localparam logic [W-1:0] CAND_ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W:0]   CNT_ONE   = {{W{1'b0}}, 1'b1};
  localparam logic [W:0]   MAX_SOL_W = (W+1)'(MAX_SOL);
  localparam bit           HAS_MAX   = (MAX_SOL != 0);

  enum_state_t  state_q;
  logic [W-1:0] cand_q;
  logic [W:0]   remaining_q, remaining_d;
  logic [W:0]   sol_count_q, sol_count_d;
  logic         busy_q, done_q, exhausted_q;

  logic in_probe, slot_free, advance, hit_load;

  // A hit only moves on when the output slot can take it; misses always move on.
  assign in_probe    = (state_q == PROBE);
  assign slot_free   = !bus.sol_valid || bus.sol_ready;
  assign advance     = in_probe && (!bus.chk_x || slot_free);
  assign hit_load    = in_probe && bus.chk_x && slot_free && !abort;
  assign remaining_d = advance ? remaining_q - CNT_ONE : remaining_q;
  assign sol_count_d = hit_load ? sol_count_q + CNT_ONE : sol_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cand_q      <= '0;
      remaining_q <= '0;
      sol_count_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      exhausted_q <= 1'b0;
    end else if (abort) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            cand_q      <= cfg_base;
            remaining_q <= cfg_limit;
            sol_count_q <= '0;
            if (cfg_limit == '0) begin
              state_q     <= DONE;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              exhausted_q <= 1'b1;
            end else begin
              state_q     <= PROBE;
              busy_q      <= 1'b1;
              done_q      <= 1'b0;
              exhausted_q <= 1'b0;
            end
          end
        end
        PROBE: begin
          if (advance) cand_q <= cand_q + CAND_ONE;
          remaining_q <= remaining_d;
          sol_count_q <= sol_count_d;
          // Range exhaustion wins over the solution cap when both land together.
          if (advance && remaining_d == '0) begin
            state_q     <= DRAIN;
            exhausted_q <= 1'b1;
          end else if (HAS_MAX && hit_load && sol_count_d == MAX_SOL_W) begin
            state_q     <= DRAIN;
            exhausted_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (slot_free) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  split_sol_slot #(.W(W)) u_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (hit_load),
    .data_i   (cand_q),
    .accept_i (bus.sol_valid && bus.sol_ready),
    .flush_i  (abort),
    .valid_o  (bus.sol_valid),
    .data_o   (bus.sol_data)
  );

  assign bus.cand  = cand_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sol_count = sol_count_q;
  assign exhausted = exhausted_q;

endmodule

// File: tb/tb_split_assign_enum.sv
// Directed bench for split_assign_enum with an in-bench checker and a handshake monitor.
module tb_split_assign_enum;
  import split_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] cfg_base = '0;
  logic [W:0]   cfg_limit = '0;
  logic         busy, done, exhausted;
  logic [W:0]   sol_count;
  logic         ready = 1'b1;
  logic         and_mode = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [W-1:0] got_q[$];
  int           stamp_q[$];
  logic [W-1:0] exp_q[$];

  split_assign_enum_if #(.W(W)) ifc ();

  // Checker model: constant-true, or x = cand[1] & cand[0].
  assign ifc.chk_x     = and_mode ? (ifc.cand[1] & ifc.cand[0]) : 1'b1;
  assign ifc.sol_ready = ready;

  split_assign_enum #(.W(W), .MAX_SOL(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .cfg_base  (cfg_base),
    .cfg_limit (cfg_limit),
    .bus       (ifc.master),
    .busy      (busy),
    .done      (done),
    .sol_count (sol_count),
    .exhausted (exhausted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (rst_n && ifc.sol_valid && ifc.sol_ready) begin
      got_q.push_back(ifc.sol_data);
      stamp_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_run(input logic [W-1:0] base, input logic [W:0] limit);
    got_q.delete();
    stamp_q.delete();
    @(negedge clk);
    cfg_base  = base;
    cfg_limit = limit;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!ifc.sol_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(ifc.sol_valid), 32'd1);
  endtask

  task automatic compare_seq(input string tag);
    check({tag, "_nsol"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check($sformatf("%s_sol%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cand"}, 32'(ifc.cand), 32'd0);
    check({tag, "_valid"}, 32'(ifc.sol_valid), 32'd0);
    check({tag, "_data"}, 32'(ifc.sol_data), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_count"}, 32'(sol_count), 32'd0);
    check({tag, "_exh"}, 32'(exhausted), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_all_zero("rst");
    rst_n = 1'b1;

    // Constant-true, 5 candidates, back-to-back solutions
    ready = 1'b1;
    and_mode = 1'b0;
    start_run(16'h0000, 17'd5);
    check("t1_busy", 32'(busy), 32'd1);
    wait_done("t1", 50);
    exp_q = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4};
    compare_seq("t1");
    for (int i = 1; i < 5; i++) begin
      if (i < stamp_q.size()) check($sformatf("t1_gap%0d", i), 32'(stamp_q[i] - stamp_q[0]), 32'(i));
    end
    check("t1_exh", 32'(exhausted), 32'd1);
    check("t1_count", 32'(sol_count), 32'd5);
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_cand", 32'(ifc.cand), 32'd5);

    // cand[1]&cand[0] over 0..15
    and_mode = 1'b1;
    start_run(16'h0000, 17'd16);
    wait_done("t2", 100);
    exp_q = '{16'd3, 16'd7, 16'd11, 16'd15};
    compare_seq("t2");
    check("t2_count", 32'(sol_count), 32'd4);
    check("t2_exh", 32'(exhausted), 32'd1);

    // Solution cap of 8 reached before the range ends
    and_mode = 1'b0;
    start_run(16'h0000, 17'd100);
    wait_done("t3", 100);
    exp_q = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7};
    compare_seq("t3");
    check("t3_count", 32'(sol_count), 32'd8);
    check("t3_exh", 32'(exhausted), 32'd0);
    check("t3_cand", 32'(ifc.cand), 32'd8);

    // Candidate wraps from all-ones to zero
    start_run(16'hFFFE, 17'd4);
    wait_done("t4", 50);
    exp_q = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    compare_seq("t4");
    check("t4_cand", 32'(ifc.cand), 32'd2);
    check("t4_exh", 32'(exhausted), 32'd1);

    // Backpressure: first solution held while the consumer stalls
    ready = 1'b0;
    start_run(16'h0000, 17'd6);
    wait_valid("t5", 20);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t5_hold_valid%0d", i), 32'(ifc.sol_valid), 32'd1);
      check($sformatf("t5_hold_data%0d", i), 32'(ifc.sol_data), 32'd0);
      check($sformatf("t5_hold_cand%0d", i), 32'(ifc.cand), 32'd1);
      if (i < 2) @(negedge clk);
    end
    ready = 1'b1;
    wait_done("t5", 50);
    exp_q = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
    compare_seq("t5");
    check("t5_count", 32'(sol_count), 32'd6);

    // Abort with a pending solution
    ready = 1'b0;
    start_run(16'h0000, 17'd10);
    wait_valid("t6", 20);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t6_valid", 32'(ifc.sol_valid), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    check("t6_count", 32'(sol_count), 32'd1);
    @(negedge clk);
    check("t6_nsol", 32'(got_q.size()), 32'd0);
    check("t6_idle_busy", 32'(busy), 32'd0);

    // Empty range finishes immediately
    ready = 1'b1;
    start_run(16'h1234, 17'd0);
    check("t7_done", 32'(done), 32'd1);
    check("t7_exh", 32'(exhausted), 32'd1);
    check("t7_count", 32'(sol_count), 32'd0);
    check("t7_valid", 32'(ifc.sol_valid), 32'd0);
    check("t7_busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-run
    start_run(16'h0005, 17'd50);
    repeat (3) @(negedge clk);
    check("t8_busy_pre", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("t8");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/split_assign_enum.md
Name: split_assign_enum

Overview:
- Generator side of the split-constraint interface. A split checker consumes a packed variable assignment and returns a single satisfied bit `x`; this block produces those assignments.
- Walks a configured range of packed candidate assignments, one per cycle, and drives each to an external split checker.
- Samples the checker's `x` and streams every satisfying candidate out on a valid/ready port.
- Feeds BDD-solver regression and sampling: it enumerates solutions of any split_N checker.

Parameters:
- W, 16, packed assignment width (concatenated var_* bits, LSB = var_0 bit 0).
- MAX_SOL, 8, stop after this many solutions; 0 = unlimited.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a run when idle.
- abort  input  1  synchronous cancel; takes priority over everything except reset.
- cfg_base  input  W  first candidate; sampled on accepted start.
- cfg_limit  input  W+1  number of candidates to probe (up to 2^W); sampled on accepted start.
- cand  output  W  current candidate to the checker (registered).
- chk_x  input  1  checker result for `cand`, combinational in the same cycle.
- sol_valid  output  1  solution available.
- sol_ready  input  1  consumer accepts when sol_valid & sol_ready.
- sol_data  output  W  satisfying assignment.
- busy  output  1  high in PROBE or DRAIN.
- done  output  1  level; high in DONE until the next accepted start.
- sol_count  output  W+1  solutions found this run.
- exhausted  output  1  with done: 1 = range fully probed; 0 = stopped at MAX_SOL.

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; cand=0, sol_data=0, sol_valid=0, busy=0, done=0, sol_count=0, exhausted=0, internal remaining=0.
- States: IDLE, PROBE, DRAIN, DONE.
- IDLE/DONE, on start:
  - Load cand=cfg_base, remaining=cfg_limit, sol_count=0; clear done and exhausted.
  - If cfg_limit==0: go to DONE next cycle with exhausted=1.
  - Otherwise go to PROBE.
- start during PROBE or DRAIN is ignored.
- PROBE, each cycle:
  - A hit is chk_x=1; the output slot is free when !sol_valid | sol_ready.
  - Advance when chk_x=0, or on a hit with a free slot. On advance: cand = cand+1 mod 2^W (wraps from all-ones to 0), remaining -= 1.
  - Hit with a free slot: sol_data <= cand, sol_valid <= 1, sol_count += 1.
  - Hit with a full slot: stall; cand and remaining hold, and chk_x is re-evaluated next cycle.
  - Latency: a hit on candidate c appears as sol_valid/sol_data=c on the next cycle.
  - Throughput: one candidate per cycle while sol_ready=1.
- PROBE termination, checked after the advance:
  - remaining reaches 0 → exhausted=1, go to DRAIN.
  - sol_count reaches MAX_SOL (MAX_SOL≠0) → exhausted=0, go to DRAIN. If both happen in the same cycle, exhausted=1.
- Output handshake:
  - When sol_valid & sol_ready and no new hit is loaded, sol_valid falls.
  - Simultaneous accept and new hit: sol_valid stays 1 and sol_data is replaced by the new hit.
  - sol_data is stable while sol_valid & !sol_ready.
- DRAIN: wait until sol_valid=0, or until the handshake completes this cycle, then go to DONE.
- DONE: done=1, busy=0; cand holds its last value.
- abort, in any state:
  - Next cycle: IDLE, sol_valid=0, busy=0, done=0; sol_count holds.
  - A pending solution is discarded.
- Reset mid-run gives the reset values immediately (asynchronous); no partial output survives.
- Widths:
  - remaining and sol_count are W+1 bits so a full 2^W range is representable.
  - cand arithmetic is W bits, modulo.

Decomposition:
- Shared package split_pkg:
  - state enum enum_state_t {IDLE, PROBE, DRAIN, DONE};
  - default width constant SPLIT_W=16.
- One natural sub-module: split_sol_slot, a single-entry valid/ready output register with load/accept/flush inputs.
  - The FSM and the candidate counter stay in the top.

Test Plan:
- Constant-true checker (chk_x tied 1), base=0, limit=5, sol_ready=1 → sol_data 0,1,2,3,4 on consecutive cycles; done with exhausted=1; sol_count=5.
- Checker x=cand[1]&cand[0], base=0, limit=16, MAX_SOL=0, sol_ready=1 → solutions 3,7,11,15; sol_count=4; exhausted=1.
- Constant-true checker, MAX_SOL=8, limit=100 → exactly 8 solutions (0..7); done with exhausted=0.
- Wrap: W=16, base=16'hFFFE, limit=4, constant-true checker → sol_data FFFE, FFFF, 0000, 0001.
- Backpressure: sol_ready=0 for 3 cycles after the first hit with a constant-true checker → sol_data=0 held stable and cand holds 1; after release, sequence continues 1, 2, … with no loss or duplication.
- abort in PROBE with sol_valid=1 → next cycle sol_valid=0, busy=0, state IDLE. limit=0 start → done next cycle, sol_count=0, no sol_valid. rst_n low mid-run → all outputs 0 asynchronously.
